// File: rtl/clk_div_multi_if.sv
// Bus bundle for the multi-channel tick generator: run enables, divisor
// configuration, the phase-align strobe and the per-channel outputs.
interface clk_div_multi_if #(
  parameter int NCH   = 4,
  parameter int CNT_W = 8,
  parameter int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
);
  logic [NCH-1:0]       enable;
  logic                 cfg_we;
  logic [CH_W-1:0]      cfg_ch;
  logic [CNT_W-1:0]     cfg_div;
  logic                 sync;
  logic [NCH-1:0]       tick;
  logic [NCH-1:0]       sq;
  logic [NCH*CNT_W-1:0] div_act;

  // Side that drives enables and configuration and consumes ticks
  modport master (
    output enable, cfg_we, cfg_ch, cfg_div, sync,
    input  tick, sq, div_act
  );

  // Side that implements the divider channels
  modport slave (
    input  enable, cfg_we, cfg_ch, cfg_div, sync,
    output tick, sq, div_act
  );
endinterface

// File: rtl/clk_div_multi.sv
// Multi-channel programmable tick generator. Each channel counts down from
// its active divisor and emits a one-cycle tick plus a square-wave toggle on
// every reload. New divisors are shadowed in div_pend and only picked up at
// the channel's next reload (or at a sync strobe), so a running period is
// never disturbed by configuration writes.
module clk_div_multi #(
  parameter int NCH         = 4,
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 1
) (
  input  logic           clk,
  input  logic           rst,
  clk_div_multi_if.slave bus
);

  localparam int              CH_W    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] ZERO    = {CNT_W{1'b0}};

  logic [CNT_W-1:0] cnt_r  [NCH];
  logic [CNT_W-1:0] pend_r [NCH];
  logic [CNT_W-1:0] act_r  [NCH];
  logic [NCH-1:0]   tick_r;
  logic [NCH-1:0]   sq_r;

  logic [CNT_W-1:0] cnt_s  [NCH];
  logic [CNT_W-1:0] pend_s [NCH];
  logic [CNT_W-1:0] act_s  [NCH];
  logic [CNT_W-1:0] load_s [NCH];
  logic [NCH-1:0]   tick_s;
  logic [NCH-1:0]   sq_s;
  logic [NCH-1:0]   hit_s;

  // Per-channel next state: sync load, reload on zero, countdown, or freeze
  always_comb begin
    tick_s = {NCH{1'b0}};
    sq_s   = sq_r;
    hit_s  = {NCH{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      cnt_s[i]  = cnt_r[i];
      act_s[i]  = act_r[i];
      pend_s[i] = pend_r[i];
      // cfg_ch values at or beyond NCH never match a channel, so such writes drop
      hit_s[i]  = (bus.cfg_we == 1'b1) && (bus.cfg_ch == CH_W'(i));
      // A write coinciding with sync bypasses straight into the sync load
      if (hit_s[i]) begin
        load_s[i] = bus.cfg_div;
        pend_s[i] = bus.cfg_div;
      end else begin
        load_s[i] = pend_r[i];
        pend_s[i] = pend_r[i];
      end

      if (bus.sync == 1'b1) begin
        cnt_s[i]  = load_s[i];
        act_s[i]  = load_s[i];
        tick_s[i] = 1'b0;
        sq_s[i]   = 1'b0;
      end else if (bus.enable[i] == 1'b1) begin
        if (cnt_r[i] == ZERO) begin
          // Reload uses the pending value as it stood before this edge
          cnt_s[i]  = pend_r[i];
          act_s[i]  = pend_r[i];
          tick_s[i] = 1'b1;
          sq_s[i]   = ~sq_r[i];
        end else begin
          cnt_s[i]  = cnt_r[i] - ONE;
          tick_s[i] = 1'b0;
        end
      end else begin
        // Disabled: count and square output freeze so the period resumes intact
        cnt_s[i]  = cnt_r[i];
        tick_s[i] = 1'b0;
      end
    end
  end

  // State and output registers with synchronous reset to the default divisor
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_r[i]  <= ZERO;
        pend_r[i] <= DEF_DIV;
        act_r[i]  <= DEF_DIV;
      end
      tick_r <= {NCH{1'b0}};
      sq_r   <= {NCH{1'b0}};
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cnt_r[i]  <= cnt_s[i];
        pend_r[i] <= pend_s[i];
        act_r[i]  <= act_s[i];
      end
      tick_r <= tick_s;
      sq_r   <= sq_s;
    end
  end

  assign bus.tick = tick_r;
  assign bus.sq   = sq_r;

  for (genvar g = 0; g < NCH; g++) begin : g_pack
    assign bus.div_act[g*CNT_W +: CNT_W] = act_r[g];
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: directed scenarios with hand-derived
// tick gaps, followed by randomized traffic compared cycle by cycle against a
// behavioural model of each channel's countdown.
module tb_clk_div_multi;

  localparam int NCH   = 5;
  localparam int CNT_W = 8;
  localparam int DEF   = 1;
  localparam int CH_W  = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  clk_div_multi_if #(.NCH(NCH), .CNT_W(CNT_W), .CH_W(CH_W)) bus ();

  clk_div_multi #(.NCH(NCH), .CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Model: cycles left before the next reload, pending and active divisors
  int   m_left [NCH];
  int   m_pend [NCH];
  int   m_act  [NCH];
  logic m_tick [NCH];
  logic m_sq   [NCH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit hit;
    int ld;
    for (int i = 0; i < NCH; i++) begin
      hit = (bus.cfg_we === 1'b1) && (int'(bus.cfg_ch) == i);
      if (rst === 1'b1) begin
        m_left[i] = 0; m_pend[i] = DEF; m_act[i] = DEF;
        m_tick[i] = 1'b0; m_sq[i] = 1'b0;
      end else begin
        if (bus.sync === 1'b1) begin
          ld = hit ? int'(bus.cfg_div) : m_pend[i];
          m_left[i] = ld; m_act[i] = ld; m_tick[i] = 1'b0; m_sq[i] = 1'b0;
        end else if (bus.enable[i] === 1'b1) begin
          if (m_left[i] == 0) begin
            m_left[i] = m_pend[i]; m_act[i] = m_pend[i];
            m_tick[i] = 1'b1; m_sq[i] = ~m_sq[i];
          end else begin
            m_left[i] = m_left[i] - 1; m_tick[i] = 1'b0;
          end
        end else begin
          m_tick[i] = 1'b0;
        end
        if (hit) m_pend[i] = int'(bus.cfg_div);
      end
    end
  endtask

  task automatic model_check();
    logic [NCH-1:0]       et;
    logic [NCH-1:0]       es;
    logic [NCH*CNT_W-1:0] ea;
    for (int i = 0; i < NCH; i++) begin
      et[i] = m_tick[i];
      es[i] = m_sq[i];
      ea[i*CNT_W +: CNT_W] = CNT_W'(m_act[i]);
    end
    chk("model_tick", 64'(bus.tick), 64'(et));
    chk("model_sq", 64'(bus.sq), 64'(es));
    chk("model_div_act", 64'(bus.div_act), 64'(ea));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    model_check();
  endtask

  // Cycles until channel ch ticks (-1 if the budget runs out)
  task automatic wait_tick(input int ch, input int limit, output int n);
    n = -1;
    for (int k = 1; k <= limit; k++) begin
      cycle();
      if (bus.tick[ch] === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  // Cycles until channel ch ticks with div_act equal to val
  task automatic wait_tick_act(input int ch, input int val, input int limit, output int n);
    n = -1;
    for (int k = 1; k <= limit; k++) begin
      cycle();
      if (bus.tick[ch] === 1'b1 && int'(bus.div_act[ch*CNT_W +: CNT_W]) == val) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic write_div(input int ch, input int val);
    bus.cfg_we  = 1'b1;
    bus.cfg_ch  = CH_W'(ch);
    bus.cfg_div = CNT_W'(val);
    cycle();
    bus.cfg_we  = 1'b0;
  endtask

  logic [NCH*CNT_W-1:0] def_pk;
  int n, k, ones, toggles, first0, first1;
  logic prev_sq;

  initial begin
    for (int i = 0; i < NCH; i++) begin
      m_left[i] = 0; m_pend[i] = DEF; m_act[i] = DEF; m_tick[i] = 1'b0; m_sq[i] = 1'b0;
      def_pk[i*CNT_W +: CNT_W] = CNT_W'(DEF);
    end
    rst = 1'b1;
    bus.enable = {NCH{1'b0}}; bus.cfg_we = 1'b0; bus.cfg_ch = {CH_W{1'b0}};
    bus.cfg_div = {CNT_W{1'b0}}; bus.sync = 1'b0;

    // Reset state
    cycle(); cycle();
    chk("rst_tick", 64'(bus.tick), 64'd0);
    chk("rst_sq", 64'(bus.sq), 64'd0);
    chk("rst_div_act", 64'(bus.div_act), 64'(def_pk));

    // Default divisor on channel 0: first tick one cycle after enable, then 1 of 2
    rst = 1'b0;
    bus.enable = 5'b00001;
    cycle();
    chk("first_tick", 64'(bus.tick[0]), 64'd1);
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      ones += int'(bus.tick[0]);
    end
    chk("div1_tick_count", 64'(ones), 64'd4);
    chk("idle_ch_tick", 64'(bus.tick[4:1]), 64'd0);

    // Channel 2 divisor 5 written mid-count: picked up at next reload, period 6
    bus.enable = 5'b00101;
    cycle(); cycle(); cycle();
    write_div(2, 5);
    wait_tick_act(2, 5, 6, n);
    chk("ch2_reload5_seen", 64'(n > 0), 64'd1);
    wait_tick(2, 10, n);
    chk("ch2_gap6_a", 64'(n), 64'd6);
    wait_tick(2, 10, n);
    chk("ch2_gap6_b", 64'(n), 64'd6);

    // Divisor 0 on channel 1: tick every cycle, sq toggles every cycle
    bus.enable = 5'b00111;
    write_div(1, 0);
    wait_tick_act(1, 0, 6, n);
    chk("ch1_reload0_seen", 64'(n > 0), 64'd1);
    ones = 0; toggles = 0;
    for (int i = 0; i < 6; i++) begin
      prev_sq = bus.sq[1];
      cycle();
      ones += int'(bus.tick[1]);
      toggles += int'(bus.sq[1] != prev_sq);
    end
    chk("ch1_div0_ticks", 64'(ones), 64'd6);
    chk("ch1_div0_toggles", 64'(toggles), 64'd6);

    // Channel 0 divisor 3, enable dropped for 3 cycles mid-count -> gap 4+3
    write_div(0, 3);
    wait_tick_act(0, 3, 8, n);
    chk("ch0_reload3_seen", 64'(n > 0), 64'd1);
    cycle();
    bus.enable[0] = 1'b0;
    cycle(); cycle(); cycle();
    bus.enable[0] = 1'b1;
    wait_tick(0, 10, k);
    chk("ch0_paused_gap", 64'(4 + k), 64'd7);

    // Sync with a coincident write to channel 1
    write_div(0, 2);
    write_div(1, 4);
    bus.enable = 5'b00011;
    for (int i = 0; i < 9; i++) cycle();
    bus.sync = 1'b1; bus.cfg_we = 1'b1; bus.cfg_ch = 3'd1; bus.cfg_div = 8'd7;
    cycle();
    bus.sync = 1'b0; bus.cfg_we = 1'b0;
    chk("sync_tick", 64'(bus.tick), 64'd0);
    chk("sync_sq", 64'(bus.sq), 64'd0);
    chk("sync_act_ch0", 64'(bus.div_act[0 +: CNT_W]), 64'd2);
    chk("sync_act_ch1", 64'(bus.div_act[CNT_W +: CNT_W]), 64'd7);
    first0 = -1; first1 = -1;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      if (bus.tick[0] === 1'b1 && first0 < 0) first0 = i;
      if (bus.tick[1] === 1'b1 && first1 < 0) first1 = i;
    end
    chk("sync_first_ch0", 64'(first0), 64'd3);
    chk("sync_first_ch1", 64'(first1), 64'd8);

    // Write to cfg_ch == NCH is dropped; then reset mid-count
    write_div(NCH, 9);
    wait_tick(1, 12, n);
    chk("oob_ch1_tick_seen", 64'(n > 0), 64'd1);
    chk("oob_ch1_act", 64'(bus.div_act[CNT_W +: CNT_W]), 64'd7);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("midrst_tick", 64'(bus.tick), 64'd0);
    chk("midrst_sq", 64'(bus.sq), 64'd0);
    chk("midrst_div_act", 64'(bus.div_act), 64'(def_pk));

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      bus.enable  = NCH'($urandom);
      bus.cfg_we  = ($urandom_range(3, 0) == 0);
      bus.cfg_ch  = CH_W'($urandom_range(7, 0));
      bus.cfg_div = CNT_W'($urandom_range(6, 0));
      bus.sync    = ($urandom_range(31, 0) == 0);
      rst         = ($urandom_range(99, 0) == 0);
      cycle();
    end
    rst = 1'b0; bus.cfg_we = 1'b0; bus.sync = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
